// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock controller.
//   state_e  : controller FSM states
//   NCH, DW  : default channel count and half-period width
//   HP0..HP2 : reset half-periods (50/10/1 MHz from a 100 MHz source)
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_e;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int HP0 = 1;
  localparam int HP1 = 5;
  localparam int HP2 = 50;

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: half-period register, counter and toggle flop.
//   clk_i/rst_i : clock, async active-high reset
//   apply_i     : load apply_hp_i and restart with a full low phase
//   apply_hp_i  : new half-period (0 disables)
//   clk_o       : divided clock
//   fall_o      : this cycle's edge toggles clk_o 1 -> 0
//   off_o       : channel disabled (half-period is 0)
module clk_div_chan #(
  parameter int DW     = 8,
  parameter int HP_RST = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          apply_i,
  input  logic [DW-1:0] apply_hp_i,
  output logic          clk_o,
  output logic          fall_o,
  output logic          off_o
);

  logic [DW-1:0] hp_q, hp_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          wrap;

  assign off_o  = (hp_q == '0);
  assign wrap   = !off_o && (cnt_q == hp_q - DW'(1));
  assign fall_o = wrap && out_q;
  assign clk_o  = out_q;

  always_comb begin
    hp_d  = hp_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (apply_i) begin
      // Restart from the beginning of a low phase with the new divisor.
      hp_d  = apply_hp_i;
      cnt_d = '0;
      out_d = 1'b0;
    end else if (off_o) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      out_d = ~out_q;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hp_q  <= DW'(HP_RST);
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      hp_q  <= hp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: NCH independent clock dividers whose half-periods
// are reprogrammed glitch-free through a valid/ready config port.
//   CLK_in, RST        : clock, async active-high reset
//   cfg_valid/ready    : config handshake
//   cfg_ch, cfg_div    : target channel, new half-period (0 disables)
//   CLK_OUT            : divided clocks
//   busy               : a request is waiting for / performing its apply
//   cfg_err            : one-cycle pulse after a bad channel index
module clk_div_ctrl #(
  parameter int NCH = clk_div_pkg::NCH,
  parameter int DW  = clk_div_pkg::DW,
  parameter int HP0 = clk_div_pkg::HP0,
  parameter int HP1 = clk_div_pkg::HP1,
  parameter int HP2 = clk_div_pkg::HP2
) (
  input  logic           CLK_in,
  input  logic           RST,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  output logic [NCH-1:0] CLK_OUT,
  output logic           busy,
  output logic           cfg_err
);
  import clk_div_pkg::*;

  state_e        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [DW-1:0] div_q, div_d;
  logic          err_q, err_d;
  logic          ch_ok;

  logic [NCH-1:0] apply, fall, off;

  assign ch_ok     = int'(cfg_ch) < NCH;
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cfg_err   = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int HPR = (g == 0) ? HP0 : (g == 1) ? HP1 : HP2;
    // Running target: apply on its falling edge. Disabled target: apply now.
    assign apply[g] = (state_q == PEND) && (int'(ch_q) == g) && (fall[g] || off[g]);

    clk_div_chan #(.DW(DW), .HP_RST(HPR)) u_chan (
      .clk_i      (CLK_in),
      .rst_i      (RST),
      .apply_i    (apply[g]),
      .apply_hp_i (div_q),
      .clk_o      (CLK_OUT[g]),
      .fall_o     (fall[g]),
      .off_o      (off[g])
    );
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    div_d   = div_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (ch_ok) begin
            ch_d    = cfg_ch;
            div_d   = cfg_div;
            state_d = PEND;
          end else begin
            // Bad index: consumed, flagged, nothing changes.
            err_d = 1'b1;
          end
        end
      end
      PEND:    if (|apply) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ch_q    <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random reconfiguration,
// compared each cycle against an arithmetic model of every channel.
module tb_clk_div_ctrl;
  localparam int NCH = 3;
  localparam int DW  = 8;

  logic           CLK_in = 1'b0;
  logic           RST = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic           cfg_ready, busy, cfg_err;
  logic [NCH-1:0] CLK_OUT;

  always #5 CLK_in = ~CLK_in;

  clk_div_ctrl dut (
    .CLK_in    (CLK_in),
    .RST       (RST),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .CLK_OUT   (CLK_OUT),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: output after edge n is ((n - t0) / hp) % 2, 0 when hp == 0.
  int n;
  int m_hp[NCH];
  int m_t0[NCH];
  bit m_pend, m_appl, m_err, acc;
  int m_ch, m_div;
  int first_hi[NCH];

  function automatic int mout(input int i, input int t);
    if (m_hp[i] == 0) return 0;
    return ((t - m_t0[i]) / m_hp[i]) % 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_hp = '{1, 5, 50};
    m_t0 = '{0, 0, 0};
    m_pend = 0; m_appl = 0; m_err = 0; acc = 0;
    first_hi = '{-1, -1, -1};
  endtask

  task automatic check_outs();
    for (int i = 0; i < NCH; i++)
      chk($sformatf("clk_out%0d", i), 32'(CLK_OUT[i]), 32'(mout(i, n)));
    chk("cfg_ready", 32'(cfg_ready), 32'(!(m_pend || m_appl)));
    chk("busy", 32'(busy), 32'(m_pend || m_appl));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  // Advance the model across edge n+1 using the inputs now applied.
  task automatic model_edge();
    bit nerr;
    nerr = 0;
    acc = 0;
    if (m_appl) begin
      m_appl = 0;
    end else if (m_pend) begin
      if (m_hp[m_ch] == 0 || (mout(m_ch, n) == 1 && mout(m_ch, n + 1) == 0)) begin
        m_hp[m_ch] = m_div;
        m_t0[m_ch] = n + 1;
        m_pend = 0;
        m_appl = 1;
      end
    end else if (cfg_valid) begin
      acc = 1;
      if (int'(cfg_ch) < NCH) begin
        m_pend = 1; m_ch = int'(cfg_ch); m_div = int'(cfg_div);
      end else begin
        nerr = 1;
      end
    end
    m_err = nerr;
  endtask

  task automatic cyc();
    check_outs();
    for (int i = 0; i < NCH; i++)
      if (CLK_OUT[i] === 1'b1 && first_hi[i] < 0) first_hi[i] = n;
    model_edge();
    @(posedge CLK_in);
    #1;
    n++;
  endtask

  task automatic run(input int k);
    cfg_valid = 1'b0;
    repeat (k) cyc();
  endtask

  task automatic req(input int ch, input int div);
    bit done;
    done = 0;
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_div = DW'(div);
    for (int k = 0; k < 300 && !done; k++) begin
      cyc();
      done = acc;
    end
    cfg_valid = 1'b0;
    chk("req_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (m_pend || m_appl); k++) cyc();
    chk("drain_idle", 32'(m_pend || m_appl), 32'd0);
  endtask

  task automatic check_first_hi();
    chk("first_hi0", 32'(first_hi[0]), 32'd1);
    chk("first_hi1", 32'(first_hi[1]), 32'd5);
    chk("first_hi2", 32'(first_hi[2]), 32'd50);
  endtask

  initial begin
    int nacc;
    bit found;
    model_reset();

    // Reset state, mid-cycle.
    #23;
    chk("rst_clk_out", 32'(CLK_OUT), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    @(posedge CLK_in);
    #1;
    RST = 1'b0;
    model_reset();

    // Default frequencies after release.
    run(210);
    check_first_hi();

    // ch1 -> 2 while CLK_OUT[1] is high mid-phase.
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (mout(1, n) == 1 && mout(1, n + 1) == 1) found = 1;
      else cyc();
    end
    chk("ch1_mid_high", 32'(found), 32'd1);
    req(1, 2);
    run(20);

    // Bad channel index.
    req(3, 9);
    run(12);

    // Same value rewrite restarts the phase.
    req(0, 1);
    run(8);

    // Disable ch2, then re-enable with 3.
    req(2, 0);
    drain();
    run(20);
    req(2, 3);
    run(20);

    // cfg_valid held across two back-to-back requests.
    nacc = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = DW'(2);
    for (int k = 0; k < 300 && nacc < 2; k++) begin
      cyc();
      if (acc) begin
        nacc++;
        cfg_ch = 2'd1; cfg_div = DW'(3);
      end
    end
    cfg_valid = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd2);
    run(20);

    // Random reconfiguration.
    repeat (40) begin
      run($urandom_range(0, 15));
      req($urandom_range(0, 3), $urandom_range(0, 7));
    end
    run(30);

    // Reset while a write is pending.
    req(2, 20);
    drain();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = DW'(7);
    cyc();
    cfg_valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("rst_pend_clk_out", 32'(CLK_OUT), 32'd0);
    chk("rst_pend_busy", 32'(busy), 32'd0);
    chk("rst_pend_err", 32'(cfg_err), 32'd0);
    repeat (3) @(posedge CLK_in);
    #1;
    RST = 1'b0;
    model_reset();
    run(210);
    check_first_hi();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NCH, 3, number of divided-clock channels.
- DW, 8, width of the half-period count.
- HP0/HP1/HP2, 1/5/50, reset half-periods for ch0/ch1/ch2, giving 50/10/1 MHz from a 100 MHz CLK_in.
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK_in, in, 1, sole clock.
- RST, in, 1, asynchronous, active-high reset.
- cfg_valid, in, 1, a config request is present.
- cfg_ready, out, 1, controller can accept a request.
- cfg_ch, in, 2, target channel index.
- cfg_div, in, DW, new half-period; 0 means disable the channel.
- CLK_OUT, out, NCH, divided clocks.
- busy, out, 1, a config request is pending.
- cfg_err, out, 1, one-cycle pulse on a bad channel index.
REQ-003 The block SHALL use one clock (CLK_in) and an asynchronous, active-high reset (RST); all state elements SHALL be clocked on the rising edge of CLK_in.

Function
REQ-004 Each channel i SHALL hold an active half-period hp_i (DW bits), a counter cnt_i (DW bits) and an output register CLK_OUT[i].
REQ-005 When hp_i != 0, cnt_i SHALL increment every cycle; at cnt_i == hp_i-1, cnt_i SHALL return to 0 and CLK_OUT[i] SHALL toggle, giving a period of 2*hp_i cycles at 50% duty.
REQ-006 When hp_i == 0, cnt_i SHALL hold 0 and CLK_OUT[i] SHALL hold 0.
REQ-007 The FSM SHALL have exactly three states:
- IDLE: cfg_ready=1, busy=0.
- PEND: cfg_ready=0, busy=1.
- APPLY: cfg_ready=0, busy=1, lasts one cycle, then goes to IDLE.
REQ-008 A transfer SHALL occur only on a cycle where cfg_valid && cfg_ready; cfg_ch and cfg_div SHALL be latched on that cycle.
REQ-009 On a transfer with cfg_ch < NCH, the FSM SHALL move IDLE -> PEND.
REQ-010 On a transfer with cfg_ch >= NCH, the request SHALL be consumed, the FSM SHALL stay in IDLE, cfg_err SHALL be 1 for the next cycle only, and no hp_i SHALL change.
REQ-011 In PEND, the latched value SHALL be written into the target channel at a safe boundary, then the FSM SHALL move to APPLY. The safe boundary is:
- running channel: the cycle on which the target's CLK_OUT toggles 1 -> 0;
- disabled channel (hp==0): the first PEND cycle.
REQ-012 At the apply cycle, the target cnt SHALL be set to 0 and CLK_OUT SHALL be 0, so the new divisor starts with a full low phase; no pulse shorter than min(old, new) half-period SHALL appear.
REQ-013 Writing 0 SHALL disable the channel at the boundary of REQ-011; CLK_OUT SHALL then remain 0.
REQ-014 Writing the value already active SHALL still complete the PEND/APPLY sequence and SHALL restart the phase at the boundary.
REQ-015 Non-target channels SHALL run unaffected during PEND and APPLY.
REQ-016 cfg_valid held high while cfg_ready=0 SHALL NOT be consumed; it SHALL be accepted on the first cycle back in IDLE.

Reset
REQ-017 While RST=1, and asynchronously on its assertion:
- state=IDLE, cnt_i=0, CLK_OUT=0, cfg_err=0, busy=0;
- hp_i=HPi;
- any pending request SHALL be discarded.
REQ-018 After RST falls, cfg_ready SHALL be 1 in the first cycle, and channels SHALL start counting on the first rising edge.

Structure
REQ-019 Package clk_div_pkg SHALL hold the FSM state enum (IDLE, PEND, APPLY), NCH and the HP0..HP2 defaults.
REQ-020 Sub-module clk_div_chan SHALL implement one channel (counter, toggle, apply port, falling-boundary flag) and SHALL be instantiated NCH times; the FSM SHALL live in clk_div_ctrl.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset release at 100 MHz -> CLK_OUT[0] period 20 ns, first high 1 cycle after release; CLK_OUT[1] first high after 5 cycles, period 100 ns; CLK_OUT[2] first high after 50 cycles, period 1000 ns.
- Write ch1 cfg_div=2 while CLK_OUT[1]=1 mid-phase -> busy stays 1 until CLK_OUT[1] falls; then low 2 cycles, high 2 cycles; ch0 and ch2 undisturbed.
- Write cfg_ch=3 -> cfg_err=1 for exactly one cycle, busy never asserts, all periods unchanged.
- Write ch2 cfg_div=0, then ch2 cfg_div=3 -> CLK_OUT[2] held 0 after its next fall; re-enable applied on the first PEND cycle, then period 6 cycles starting low.
- cfg_valid held high across two back-to-back requests -> second accepted only after APPLY returns to IDLE; cfg_ready low throughout PEND and APPLY.
- RST asserted during PEND -> all outputs 0 immediately; after release defaults restored and the pending write never applied.
